// File: rtl/xcr_ctx_master.sv
// XCR control-register bus initiator: single register reads/writes plus 8-register
// context SAVE/RESTORE bursts between one slave and an internal context buffer.
module xcr_ctx_master #(
    parameter int unsigned N_SLV   = 4,
    parameter int unsigned CTX_NUM = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(N_SLV)-1:0]   cmd_sel,
    input  logic [2:0]                 cmd_adr,
    input  logic [7:0]                 cmd_wdata,
    input  logic [$clog2(CTX_NUM)-1:0] cmd_ctx,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic [N_SLV-1:0]           xcr_cs,
    output logic                       xcr_we,
    output logic [2:0]                 xcr_adr,
    output logic [7:0]                 xcr_wdata,
    input  logic [7:0]                 xcr_rdata
);

    localparam int unsigned CW = $clog2(CTX_NUM);

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_BURST, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [N_SLV-1:0] cs_q, cs_d;
    logic             we_q, we_d;
    logic [2:0]       adr_q, adr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [CW-1:0]    ctx_q, ctx_d;
    logic             mem_we;
    logic [CW+2:0]    mem_rd_idx;

    logic [7:0] ctx_mem [CTX_NUM*8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cs_q    <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ctx_q   <= ctx_d;
        end
    end

    // Context buffer is deliberately unreset; an abandoned SAVE leaves it partially updated.
    always_ff @(posedge clk) begin
        if (mem_we) ctx_mem[{ctx_q, adr_q}] <= xcr_rdata;
    end

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ctx_d      = ctx_q;
        mem_we     = 1'b0;
        mem_rd_idx = {ctx_q, adr_q + 3'd1};
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ctx_d = cmd_ctx;
                    cs_d  = N_SLV'(1) << cmd_sel;
                    we_d  = cmd_op[0];
                    if (cmd_op[1] == 1'b0) begin
                        state_d = S_SINGLE;
                        adr_d   = cmd_adr;
                        wdata_d = cmd_wdata;
                    end else begin
                        // Bursts start at address 1 so the enable register (address 0) goes last.
                        state_d    = S_BURST;
                        adr_d      = 3'd1;
                        mem_rd_idx = {cmd_ctx, 3'd1};
                        if (cmd_op[0]) wdata_d = ctx_mem[mem_rd_idx];
                    end
                end
            end
            S_SINGLE: begin
                state_d = S_RESP;
                cs_d    = '0;
                we_d    = 1'b0;
                rdata_d = we_q ? 8'h00 : xcr_rdata;
            end
            S_BURST: begin
                mem_we = ~we_q;
                if (adr_q == 3'd0) begin
                    state_d = S_RESP;
                    cs_d    = '0;
                    we_d    = 1'b0;
                    rdata_d = we_q ? 8'h00 : xcr_rdata;
                end else begin
                    adr_d = adr_q + 3'd1;
                    if (we_q) wdata_d = ctx_mem[mem_rd_idx];
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign xcr_cs    = cs_q;
    assign xcr_we    = we_q;
    assign xcr_adr   = adr_q;
    assign xcr_wdata = wdata_q;

endmodule

// File: tb/tb_xcr_ctx_master.sv
// Scoreboard bench for xcr_ctx_master: bus cycles and responses are predicted at issue
// time from a shadow register/context model and checked as the DUT produces them.
module tb_xcr_ctx_master;

    localparam int unsigned NS = 4;
    localparam int unsigned NC = 4;

    typedef struct packed {
        logic [3:0] cs;
        logic       we;
        logic [2:0] adr;
        logic [7:0] wd;
    } bus_t;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_sel;
    logic [2:0] cmd_adr;
    logic [7:0] cmd_wdata;
    logic [1:0] cmd_ctx;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [3:0] xcr_cs;
    logic       xcr_we;
    logic [2:0] xcr_adr;
    logic [7:0] xcr_wdata;
    logic [7:0] xcr_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b1;

    bus_t       exp_bus[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] sregs [NS][8];
    logic [7:0] mdl   [NS][8];
    logic [7:0] mbuf  [NC][8];
    time        t_acc;

    xcr_ctx_master #(.N_SLV(NS), .CTX_NUM(NC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_ctx(cmd_ctx),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .xcr_cs(xcr_cs), .xcr_we(xcr_we), .xcr_adr(xcr_adr), .xcr_wdata(xcr_wdata),
        .xcr_rdata(xcr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Slave register files behind the shared bus
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            if (xcr_cs[i] && xcr_we) sregs[i][xcr_adr] <= xcr_wdata;
    end

    always_comb begin
        xcr_rdata = 8'h00;
        for (int i = 0; i < NS; i++)
            if (xcr_cs[i] && !xcr_we) xcr_rdata = sregs[i][xcr_adr];
    end

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (xcr_cs == 4'b0) begin
                check("we_idle", 32'(xcr_we), 32'(0));
            end else if (exp_bus.size() == 0) begin
                check("bus_extra", 32'(xcr_cs), 32'(0));
            end else begin
                bus_t e;
                e = exp_bus.pop_front();
                check("bus_cs", 32'(xcr_cs), 32'(e.cs));
                check("bus_we", 32'(xcr_we), 32'(e.we));
                check("bus_adr", 32'(xcr_adr), 32'(e.adr));
                if (e.we) check("bus_wdata", 32'(xcr_wdata), 32'(e.wd));
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("rsp_extra", 32'(1), 32'(0));
                end else begin
                    logic [7:0] r;
                    r = exp_rsp.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(r));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic do_cmd(input logic [1:0] op, input int sel, input logic [2:0] adr,
                          input logic [7:0] wd, input int ctx, input bit hold);
        logic [3:0] cs;
        logic [2:0] a;
        int         lat;
        bit         seen;
        cs = 4'(1 << sel);
        case (op)
            2'b00: begin
                exp_bus.push_back('{cs, 1'b0, adr, 8'h00});
                exp_rsp.push_back(mdl[sel][adr]);
            end
            2'b01: begin
                exp_bus.push_back('{cs, 1'b1, adr, wd});
                exp_rsp.push_back(8'h00);
                mdl[sel][adr] = wd;
            end
            2'b10: begin
                for (int k = 1; k <= 8; k++) begin
                    a = 3'(k);
                    exp_bus.push_back('{cs, 1'b0, a, 8'h00});
                    mbuf[ctx][a] = mdl[sel][a];
                end
                exp_rsp.push_back(mdl[sel][0]);
            end
            default: begin
                for (int k = 1; k <= 8; k++) begin
                    a = 3'(k);
                    exp_bus.push_back('{cs, 1'b1, a, mbuf[ctx][a]});
                    mdl[sel][a] = mbuf[ctx][a];
                end
                exp_rsp.push_back(8'h00);
            end
        endcase
        cmd_op    = op;
        cmd_sel   = 2'(sel);
        cmd_adr   = adr;
        cmd_wdata = wd;
        cmd_ctx   = 2'(ctx);
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check("accept_rdy", 32'(cmd_ready), 32'(1));
        @(posedge clk);
        t_acc = $time;
        #1;
        if (!hold) cmd_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            check("busy_rdy", 32'(cmd_ready), 32'(0));
            lat++;
        end
        check("rsp_seen", 32'(seen), 32'(1));
        check("rsp_lat", 32'(lat), op[1] ? 32'(8) : 32'(1));
        check("rsp_rdy", 32'(cmd_ready), 32'(0));
    endtask

    initial begin
        time t0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 2'd0;
        cmd_adr = 3'd0; cmd_wdata = 8'h00; cmd_ctx = 2'd0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_cs", 32'(xcr_cs), 32'(0));
        check("rst_we", 32'(xcr_we), 32'(0));
        check("rst_adr", 32'(xcr_adr), 32'(0));
        check("rst_wdata", 32'(xcr_wdata), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_cmd(2'b01, 1, 3'd3, 8'hA5, 0, 1'b0);
        do_cmd(2'b01, 0, 3'd2, 8'h3C, 0, 1'b0);
        t0 = t_acc;
        do_cmd(2'b00, 0, 3'd2, 8'h00, 0, 1'b0);
        check("single_period", 32'(t_acc - t0), 32'(30));
        do_cmd(2'b00, 1, 3'd3, 8'h00, 0, 1'b0);
        for (int a = 0; a < 8; a++)
            do_cmd(2'b01, 0, 3'(a), 8'h10 + 8'(a), 0, 1'b0);
        do_cmd(2'b00, 0, 3'd5, 8'h00, 0, 1'b0);

        // SAVE with cmd_valid held high, then RESTORE into another slave
        do_cmd(2'b10, 0, 3'd0, 8'h00, 2, 1'b1);
        t0 = t_acc;
        do_cmd(2'b11, 2, 3'd0, 8'h00, 2, 1'b0);
        check("burst_period", 32'(t_acc - t0), 32'(100));
        @(negedge clk);
        for (int a = 0; a < 8; a++)
            check("restored_reg", 32'(sregs[2][a]), 32'(8'h10 + 8'(a)));

        // Reset during the fourth bus cycle of a RESTORE
        mon_en    = 1'b0;
        cmd_op    = 2'b11; cmd_sel = 2'd3; cmd_ctx = 2'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_cs_before", 32'(xcr_cs), 32'(4'b1000));
        rst = 1'b1;
        #1;
        check("mid_rst_cs", 32'(xcr_cs), 32'(0));
        check("mid_rst_we", 32'(xcr_we), 32'(0));
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_rsp", 32'(rsp_valid), 32'(0));
            check("post_rst_rdy", 32'(cmd_ready), 32'(1));
        end
        do_cmd(2'b00, 0, 3'd7, 8'h00, 0, 1'b0);
        do_cmd(2'b00, 2, 3'd0, 8'h00, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("bus_left", 32'(exp_bus.size()), 32'(0));
        check("rsp_left", 32'(exp_rsp.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
